// File: rtl/parity_pkg.sv
// Shared constants and state encoding for the byte-serial parity scheduler.
package parity_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

endpackage

// File: rtl/parity_scheduler_if.sv
// Request/result bundle between the clients, the parity scheduler and the consumer.
interface parity_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  import parity_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*WORD_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_parity;
  logic [ID_W-1:0]           out_id;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_parity, out_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_parity, out_id
  );

endinterface

// File: rtl/parity_scheduler_byte_parity.sv
// Single shared byte-parity unit: reduction XOR of one byte.
module byte_parity
  import parity_pkg::*;
(
  input  logic [BYTE_W-1:0] data,
  output logic              parity
);

  assign parity = ^data;

endmodule

// File: rtl/parity_scheduler.sv
// Round-robin front end sharing one byte-serial parity engine among NUM_REQ clients.
module parity_scheduler
  import parity_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  parity_scheduler_if.slave  bus,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               acc;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [WORD_W-1:0]  word_q;

  logic [NUM_REQ-1:0] rot;
  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    next_ptr;
  int unsigned        idx;
  int unsigned        pos;

  logic [BYTE_W-1:0]  cur_byte;
  logic               cur_par;

  // Rotate so rr_ptr sits at bit 0, pick the lowest set bit, then rotate back.
  always_comb begin
    rot         = '0;
    idx         = 0;
    pos         = 0;
    grant_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = k + 32'(rr_ptr);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      rot[k] = bus.req_valid[idx];
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && rot[k]) begin
        grant_found = 1'b1;
        pos         = k;
      end
    end
    pos = pos + 32'(rr_ptr);
    if (pos >= NUM_REQ) pos = pos - NUM_REQ;
    grant_idx = ID_W'(pos);
    next_ptr  = (pos == NUM_REQ - 1) ? '0 : ID_W'(pos + 1);
  end

  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && grant_found)
      bus.req_ready[grant_idx] = 1'b1;
  end

  assign cur_byte = word_q[BYTE_W*cnt +: BYTE_W];

  byte_parity u_byte_parity (
    .data   (cur_byte),
    .parity (cur_par)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      acc            <= 1'b0;
      rr_ptr         <= '0;
      gnt_id         <= '0;
      word_q         <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_parity <= 1'b0;
      bus.out_id     <= '0;
      busy           <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_found) begin
            word_q <= bus.req_data[WORD_W*grant_idx +: WORD_W];
            gnt_id <= grant_idx;
            rr_ptr <= next_ptr;
            acc    <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= COMPUTE;
          end
        end
        COMPUTE: begin
          acc <= acc ^ cur_par;
          cnt <= cnt + CNT_W'(1);
          // Final byte folds straight into the registered result.
          if (cnt == CNT_W'(BYTES_PER_WORD - 1)) begin
            bus.out_valid  <= 1'b1;
            bus.out_parity <= acc ^ cur_par ^ PARITY_ODD;
            bus.out_id     <= gnt_id;
            state          <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
